// File: rtl/timer_counter.sv
// Memory-mapped 32-bit down-counter with CTRL/PRESET/COUNT registers and a level IRQ.
// Optional `TIMER_AUTORELOAD_EN` enables CTRL[2:1] mode storage and mode-1 auto-reload.
module timer_counter (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Addr,
    input  logic        WE,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    output logic        IRQ
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CTRL_W = 4;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_CNT  = 2'd2;
    localparam logic [1:0] S_INT  = 2'd3;

    localparam logic [1:0] A_CTRL   = 2'd0;
    localparam logic [1:0] A_PRESET = 2'd1;
    localparam logic [1:0] A_COUNT  = 2'd2;

    logic [1:0]        r_state;
    logic [CTRL_W-1:0] r_ctrl;
    logic [DATA_W-1:0] r_preset;
    logic [DATA_W-1:0] r_count;
    logic              r_irq_flag;

    logic [1:0]        w_state_nxt;
    logic [CTRL_W-1:0] w_ctrl_nxt;
    logic [CTRL_W-1:0] w_fsm_ctrl;
    logic [CTRL_W-1:0] w_din_ctrl;
    logic [DATA_W-1:0] w_preset_nxt;
    logic [DATA_W-1:0] w_count_nxt;
    logic              w_irq_nxt;
    logic              w_wr_ctrl;
    logic              w_wr_preset;
    logic              w_unused_addr;

    assign w_unused_addr = ^{Addr[31:4], Addr[1:0]};
    assign w_wr_ctrl     = WE && (Addr[3:2] == A_CTRL);
    assign w_wr_preset   = WE && (Addr[3:2] == A_PRESET);

`ifdef TIMER_AUTORELOAD_EN
    assign w_din_ctrl = Din[3:0];
`else
    // Mode bits are hardwired to zero: every count is one-shot.
    assign w_din_ctrl = {Din[3], 2'b00, Din[0]};
`endif

    // Next-state and datapath logic; a bus write to CTRL overrides the FSM's Enable clear.
    always_comb begin
        w_state_nxt  = r_state;
        w_fsm_ctrl   = r_ctrl;
        w_count_nxt  = r_count;
        w_irq_nxt    = r_irq_flag;
        w_preset_nxt = r_preset;
        case (r_state)
            S_IDLE: begin
                if (r_ctrl[0]) begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                w_count_nxt = r_preset;
                w_state_nxt = S_CNT;
            end
            S_CNT: begin
                if (!r_ctrl[0]) begin
                    w_state_nxt = S_IDLE;
                end else if (r_count > DATA_W'(1)) begin
                    w_count_nxt = r_count - DATA_W'(1);
                end else begin
                    w_count_nxt = '0;
                    w_irq_nxt   = 1'b1;
                    w_state_nxt = S_INT;
                end
            end
            default: begin
`ifdef TIMER_AUTORELOAD_EN
                if (r_ctrl[2:1] == 2'b01) begin
                    w_irq_nxt = 1'b0;
                end else begin
                    w_fsm_ctrl[0] = 1'b0;
                end
`else
                w_fsm_ctrl[0] = 1'b0;
`endif
                w_state_nxt = S_IDLE;
            end
        endcase

        w_ctrl_nxt = w_wr_ctrl ? w_din_ctrl : w_fsm_ctrl;
        if (w_wr_ctrl) begin
            w_irq_nxt = 1'b0;
        end
        if (w_wr_preset) begin
            w_preset_nxt = Din;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ctrl     <= '0;
            r_preset   <= '0;
            r_count    <= '0;
            r_irq_flag <= 1'b0;
        end else begin
            r_ctrl     <= w_ctrl_nxt;
            r_preset   <= w_preset_nxt;
            r_count    <= w_count_nxt;
            r_irq_flag <= w_irq_nxt;
        end
    end

    // Zero-latency read mux so the CPU samples in the same M cycle.
    always_comb begin
        case (Addr[3:2])
            A_CTRL:   Dout = {{(DATA_W-CTRL_W){1'b0}}, r_ctrl};
            A_PRESET: Dout = r_preset;
            A_COUNT:  Dout = r_count;
            default:  Dout = '0;
        endcase
    end

    assign IRQ = r_irq_flag & r_ctrl[3];

endmodule

// File: doc/timer_counter.md
# timer_counter

Memory-mapped 32-bit down-counter that sits directly downstream of the pipelined CPU's M-stage data bus, behind the system bridge, at TC1 (0x7F00–0x7F0B) and TC2 (0x7F10–0x7F1B). Each instance exposes three word registers, CTRL, PRESET and COUNT, and runs a four-state load/count/interrupt machine. Its interrupt output drives one bit of the CPU's `HWInt[5:0]`. The CPU already raises AdEL/AdES on non-word accesses to this range and on stores to COUNT, so this block only ever sees aligned word accesses.

## Interface
- no parameters
- `clk`  in  1  system clock; all state updates on rising edge
- `reset`  in  1  asynchronous, active-low; a low level forces every register and output to its reset value
- `Addr`  in  32  byte address from the bridge; only `Addr[3:2]` is decoded (bridge performs chip select)
- `WE`  in  1  write strobe, already qualified by chip select and `m_data_byteen == 4'b1111`
- `Din`  in  32  write data
- `Dout`  out  32  read data, combinational from `Addr[3:2]`
- `IRQ`  out  1  interrupt request to `HWInt`, level

## Operation
- Registers and reset values:
  - CTRL at offset 0x0, reset 0: bit0 Enable, bits[2:1] Mode, bit3 IM (interrupt mask); bits[31:4] read 0.
  - PRESET at offset 0x4, reset 0, full 32 bits.
  - COUNT at offset 0x8, reset 0, read-only.
  - Offset 0xC reads 0.
  - Internal `irq_flag` resets to 0; the state machine resets to IDLE.
- Writes:
  - To CTRL: store `Din[3:0]` and clear `irq_flag`.
  - To PRESET: store `Din`. The new value is used at the next LOAD; it does not affect a count in progress.
  - To COUNT or offset 0xC: ignored.
- `IRQ = irq_flag & CTRL.IM`.
- State machine:
  - IDLE: if Enable is set, go to LOAD.
  - LOAD: COUNT ← PRESET, then go to CNT. This happens regardless of Enable.
  - CNT:
    - If Enable is clear, go to IDLE and hold COUNT.
    - Else if COUNT > 1, decrement COUNT.
    - Else COUNT ← 0, `irq_flag` ← 1, go to INT.
  - INT:
    - Mode 1 (auto-reload): clear `irq_flag`, go to IDLE.
    - Mode 0, 2 or 3 (one-shot): clear Enable, go to IDLE. `irq_flag` stays set until the next CTRL write.
- Boundary cases:
  - PRESET = 0 or 1 behaves like a count to 0: INT is reached on the edge after LOAD.
  - If a CTRL write and the FSM's Enable clear in INT happen on the same edge, the bus write wins for all CTRL bits. The write still clears `irq_flag`, and the FSM still moves to IDLE.
  - An asserted reset mid-count returns everything to reset values immediately; no IRQ is produced.
- Arithmetic is unsigned 32-bit. COUNT never wraps below 0.

## Timing
- `Dout` has zero latency (combinational), so the CPU samples it in the same M cycle.
- Let edge W be the edge that writes Enable = 1, with PRESET = P ≥ 1:
  - W+1: LOAD.
  - W+2: COUNT = P.
  - W+3 … W+P+1: COUNT decrements to 1.
  - W+P+2: COUNT = 0 and `irq_flag` = 1.
- Mode 1: `irq_flag` is high for exactly 1 cycle. The period is P+3 cycles, and the next rise is at W+2P+5.
- Mode 0: INT at W+P+3 clears Enable. IRQ then stays high (if IM is set) until a CTRL write.

## Configuration
- Macro: `TIMER_AUTORELOAD_EN`.
- Defined: Mode 1 auto-reload works as described, and CTRL[2:1] store and read back `Din[2:1]`.
- Undefined: CTRL[2:1] are hardwired to 0 (writes are dropped, reads return 0). Every count is one-shot mode 0, and `irq_flag` is cleared only by a CTRL write.

## Test plan
- Reset low with random inputs → `Dout` = 0 at offsets 0x0, 0x4, 0x8 and 0xC; `IRQ` = 0; after release, COUNT stays 0 for 20 cycles.
- PRESET = 5, CTRL = 0x9 (IM, mode 0, enable) at edge W → COUNT = 5 at W+2, 1 at W+6, 0 at W+7; `IRQ` rises at W+7 and stays high; CTRL reads 0x8 after W+8; writing CTRL = 0x8 drops `IRQ`.
- With `TIMER_AUTORELOAD_EN`: PRESET = 3, CTRL = 0xB → `IRQ` pulses 1 cycle at W+5, W+11 and W+17 (period 6). Without the macro, CTRL reads 0x9 and only one pulse occurs, held high.
- PRESET = 100, enable; write CTRL = 0x8 when COUNT = 40 → FSM goes to IDLE, COUNT holds 39 or 40 (the value at the disabling edge), no `IRQ`. A write to COUNT (0x8) leaves it unchanged.
- Count in progress with IM = 0 → `irq_flag` sets but `IRQ` stays 0. Writing PRESET = 2 mid-count does not alter the current count; the next reload uses 2.
- Assert reset for 1 cycle while COUNT = 7 → COUNT, CTRL and `IRQ` are 0 immediately, before the next edge; state returns to IDLE.
